// File: rtl/song_player_if.sv
// Control, RAM read port and playback status of the song player.
// The player is the master: it drives the RAM address and the status outputs.
interface song_player_if #(
    parameter int ADDR_WIDTH = 13,
    parameter int TIME_WIDTH = 13
);
    logic                  start;
    logic                  stop;
    logic [ADDR_WIDTH-1:0] ram_address;
    logic [27:0]           ram_q;
    logic [1:0]            note;
    logic                  playing;
    logic                  done;
    logic [TIME_WIDTH-1:0] play_time;

    modport master (
        input  start, stop, ram_q,
        output ram_address, note, playing, done, play_time
    );

    modport slave (
        output start, stop, ram_q,
        input  ram_address, note, playing, done, play_time
    );
endinterface

// File: rtl/song_player.sv
// Plays {key, start_time, duration} records from the song RAM in address order
// against a free-running playback tick, sounding one note at a time.
module song_player #(
    parameter int TICK_CYCLES = 500000,
    parameter int ADDR_WIDTH  = 13,
    parameter int TIME_WIDTH  = 13
) (
    input  logic          i_clock,
    input  logic          i_reset,
    song_player_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT_Q, S_CHECK, S_WAIT_START, S_SOUND, S_NEXT, S_FINISH
    } state_t;

    localparam int TCW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_CYCLES - 1);

    state_t                r_state;
    state_t                w_next;
    logic [TCW-1:0]        r_tick_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [1:0]            r_key;
    logic [TIME_WIDTH-1:0] r_start;
    logic [TIME_WIDTH-1:0] r_dur;
    logic [TIME_WIDTH-1:0] r_remaining;
    logic [TIME_WIDTH-1:0] r_play_time;
    logic                  w_playing;
    logic                  w_tick;

    assign w_playing = (r_state != S_IDLE);
    assign w_tick    = w_playing && (r_tick_cnt == TICK_LAST);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:       if (bus.start) w_next = S_FETCH;
            S_FETCH:      w_next = S_WAIT_Q;
            S_WAIT_Q:     w_next = S_CHECK;
            // Decide on the live RAM word; the record registers load on this same edge.
            S_CHECK:      w_next = (bus.ram_q[27:26] == 2'b00) ? S_FINISH : S_WAIT_START;
            S_WAIT_START: if (r_play_time >= r_start) w_next = (r_dur != '0) ? S_SOUND : S_NEXT;
            S_SOUND:      if (r_remaining == '0) w_next = S_NEXT;
            S_NEXT:       w_next = (r_addr == '1) ? S_FINISH : S_FETCH;
            S_FINISH:     w_next = S_IDLE;
            default:      w_next = S_IDLE;
        endcase
        if (bus.stop && r_state != S_IDLE && r_state != S_FINISH) w_next = S_FINISH;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_tick_cnt  <= '0;
            r_addr      <= '0;
            r_key       <= 2'b00;
            r_start     <= '0;
            r_dur       <= '0;
            r_remaining <= '0;
            r_play_time <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE) begin
                if (bus.start) begin
                    r_tick_cnt  <= '0;
                    r_addr      <= '0;
                    r_play_time <= '0;
                end
            end else begin
                r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
                if (w_tick && r_play_time != '1) r_play_time <= r_play_time + 1'b1;
            end
            if (r_state == S_CHECK) {r_key, r_start, r_dur} <= bus.ram_q;
            if (r_state == S_WAIT_START && w_next == S_SOUND)
                r_remaining <= r_dur;
            else if (r_state == S_SOUND && w_tick && r_remaining != '0)
                r_remaining <= r_remaining - 1'b1;
            if (r_state == S_NEXT && w_next == S_FETCH) r_addr <= r_addr + 1'b1;
        end
    end

    assign bus.ram_address = r_addr;
    assign bus.note        = (r_state == S_SOUND) ? r_key : 2'b00;
    assign bus.playing     = w_playing;
    assign bus.done        = (r_state == S_FINISH);
    assign bus.play_time   = r_play_time;
endmodule
